div_seq: RTL and testbench

- Multi-cycle sequencer and iterative datapath for the shared integer divider serving DIV/DIVU in the EX stage.
- Accepts a request from EX and runs a radix-2 restoring division over WIDTH iterations. Applies signed fix-up, then holds the HI/LO result until the pipeline consumes it.
- Drives the ready handshake that the hazard unit turns into the div stall.
- Aborts cleanly on an exception flush.

---
 rtl/div_seq_pkg.sv | 14 +
 rtl/div_seq_step.sv | 25 ++
 rtl/div_seq.sv | 137 +++++++++++++
 tb/tb_div_seq.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/div_seq_pkg.sv
// div_seq_pkg: shared state encoding for the iterative divider sequencer.
`default_nettype none

package div_seq_pkg;

  typedef enum logic [1:0] {
    DIVSEQ_IDLE = 2'd0,
    DIVSEQ_BUSY = 2'd1,
    DIVSEQ_DONE = 2'd2
  } divseq_state_e;

endpackage

`default_nettype wire

// File: rtl/div_seq_step.sv
// div_seq_step: one combinational radix-2 restoring division iteration.
`default_nettype none

module div_seq_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic             dvd_msb_i,
  input  logic [WIDTH-1:0] dsr_i,
  output logic [WIDTH-1:0] rem_o,
  output logic             qbit_o
);

  logic [WIDTH:0] shift;
  logic [WIDTH:0] diff;

  // The incoming remainder is always below the divisor, so the restored value fits in WIDTH bits.
  assign shift  = {rem_i, dvd_msb_i};
  assign diff   = shift - {1'b0, dsr_i};
  assign qbit_o = ~diff[WIDTH];
  assign rem_o  = qbit_o ? diff[WIDTH-1:0] : shift[WIDTH-1:0];

endmodule

`default_nettype wire

// File: rtl/div_seq.sv
// div_seq: multi-cycle DIV/DIVU sequencer with signed fix-up, hold and annul handling.
`default_nettype none

module div_seq
  import div_seq_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             div_req,
  input  logic             div_signed,
  input  logic [WIDTH-1:0] opa,
  input  logic [WIDTH-1:0] opb,
  input  logic             annul,
  input  logic             hold,
  output logic             div_ready,
  output logic             div_busy,
  output logic [WIDTH-1:0] quot,
  output logic [WIDTH-1:0] rem
);

  divseq_state_e    state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] prem_q, prem_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0] dsr_q, dsr_d;
  logic             sa_q, sa_d;
  logic             sb_q, sb_d;
  logic             sgn_q, sgn_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] rem_q, rem_d;

  logic [WIDTH-1:0] step_rem;
  logic             step_qbit;
  logic [WIDTH-1:0] qraw;

  div_seq_step #(.WIDTH(WIDTH)) u_step (
    .rem_i    (prem_q),
    .dvd_msb_i(dvd_q[WIDTH-1]),
    .dsr_i    (dsr_q),
    .rem_o    (step_rem),
    .qbit_o   (step_qbit)
  );

  // Dividend bits shift out the top while quotient bits shift in at the bottom.
  assign qraw = {dvd_q[WIDTH-2:0], step_qbit};

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= DIVSEQ_IDLE;
      cnt_q   <= '0;
      prem_q  <= '0;
      dvd_q   <= '0;
      dsr_q   <= '0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      sgn_q   <= 1'b0;
      quot_q  <= '0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      prem_q  <= prem_d;
      dvd_q   <= dvd_d;
      dsr_q   <= dsr_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      sgn_q   <= sgn_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    prem_d  = prem_q;
    dvd_d   = dvd_q;
    dsr_d   = dsr_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    sgn_d   = sgn_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    case (state_q)
      DIVSEQ_IDLE: begin
        if (div_req && !annul) begin
          if (opb == '0) begin
            quot_d  = '1;
            rem_d   = opa;
            state_d = DIVSEQ_DONE;
          end else begin
            prem_d  = '0;
            dvd_d   = (div_signed && opa[WIDTH-1]) ? -opa : opa;
            dsr_d   = (div_signed && opb[WIDTH-1]) ? -opb : opb;
            sa_d    = opa[WIDTH-1];
            sb_d    = opb[WIDTH-1];
            sgn_d   = div_signed;
            cnt_d   = '0;
            state_d = DIVSEQ_BUSY;
          end
        end
      end
      DIVSEQ_BUSY: begin
        // Losing the request mid-flight means the instruction was flushed elsewhere.
        if (annul || !div_req) begin
          state_d = DIVSEQ_IDLE;
        end else begin
          prem_d = step_rem;
          dvd_d  = qraw;
          cnt_d  = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(WIDTH - 1)) begin
            quot_d  = (sgn_q && (sa_q ^ sb_q)) ? -qraw : qraw;
            rem_d   = (sgn_q && sa_q) ? -step_rem : step_rem;
            state_d = DIVSEQ_DONE;
          end
        end
      end
      DIVSEQ_DONE: begin
        if (annul || !div_req || !hold) begin
          state_d = DIVSEQ_IDLE;
        end
      end
      default: state_d = DIVSEQ_IDLE;
    endcase
  end

  assign div_ready = (state_q == DIVSEQ_DONE);
  assign div_busy  = (state_q == DIVSEQ_BUSY);
  assign quot      = quot_q;
  assign rem       = rem_q;

endmodule

`default_nettype wire

// File: tb/tb_div_seq.sv
// tb_div_seq: directed self-checking bench for div_seq.
`timescale 1ns/1ps
`default_nettype none

module tb_div_seq;

  logic        clk;
  logic        resetn;
  logic        div_req;
  logic        div_signed;
  logic [31:0] opa;
  logic [31:0] opb;
  logic        annul;
  logic        hold;
  logic        div_ready;
  logic        div_busy;
  logic [31:0] quot;
  logic [31:0] rem;

  int checks;
  int failures;

  div_seq #(.WIDTH(32), .CNT_W(6)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .div_req   (div_req),
    .div_signed(div_signed),
    .opa       (opa),
    .opb       (opb),
    .annul     (annul),
    .hold      (hold),
    .div_ready (div_ready),
    .div_busy  (div_busy),
    .quot      (quot),
    .rem       (rem)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Presents a request and counts edges (accepting edge included) until div_ready.
  task automatic run_div(input logic [31:0] a, input logic [31:0] b, input logic s,
                         output int edges, output int busy_cycles, output int overlap);
    logic done;
    @(negedge clk);
    opa = a; opb = b; div_signed = s; div_req = 1'b1;
    edges = 0; busy_cycles = 0; overlap = 0; done = 1'b0;
    for (int i = 0; i < 100 && !done; i++) begin
      @(posedge clk); #1;
      edges++;
      if (div_busy) busy_cycles++;
      if (div_busy && div_ready) overlap++;
      if (div_ready) done = 1'b1;
    end
  endtask

  task automatic release_req();
    @(negedge clk);
    div_req = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    resetn = 1'b0; div_req = 1'b0; div_signed = 1'b0; opa = '0; opb = '0;
    annul = 1'b0; hold = 1'b0;
    #2;
    checks++;
    if (div_ready !== 1'b0 || div_busy !== 1'b0) begin
      failures++; $display("FAIL reset_flags ready=%b busy=%b expected 0/0", div_ready, div_busy);
    end
    checks++;
    if (quot !== 32'h0 || rem !== 32'h0) begin
      failures++; $display("FAIL reset_result quot=%h rem=%h expected 0/0", quot, rem);
    end
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_unsigned();
    int e, b, o;
    run_div(32'd100, 32'd7, 1'b0, e, b, o);
    checks++;
    if (e !== 33) begin failures++; $display("FAIL udiv_latency got=%0d expected=33", e); end
    checks++;
    if (b !== 32) begin failures++; $display("FAIL udiv_busy_cycles got=%0d expected=32", b); end
    checks++;
    if (o !== 0) begin failures++; $display("FAIL udiv_overlap got=%0d expected=0", o); end
    checks++;
    if (quot !== 32'd14 || rem !== 32'd2) begin
      failures++; $display("FAIL udiv_result quot=%0d rem=%0d expected 14/2", quot, rem);
    end
    release_req();
    checks++;
    if (div_ready !== 1'b0) begin failures++; $display("FAIL udiv_ready_drop got=%b expected=0", div_ready); end
    run_div(32'hFFFF_FFF9, 32'd2, 1'b0, e, b, o);
    checks++;
    if (quot !== 32'h7FFF_FFFC || rem !== 32'h1) begin
      failures++; $display("FAIL udiv_big quot=%h rem=%h expected 7ffffffc/00000001", quot, rem);
    end
    release_req();
  endtask

  task automatic test_signed();
    int e, b, o;
    run_div(32'hFFFF_FFF9, 32'd2, 1'b1, e, b, o);
    checks++;
    if (quot !== 32'hFFFF_FFFD || rem !== 32'hFFFF_FFFF) begin
      failures++; $display("FAIL sdiv_neg_dividend quot=%h rem=%h expected fffffffd/ffffffff", quot, rem);
    end
    checks++;
    if (e !== 33) begin failures++; $display("FAIL sdiv_latency got=%0d expected=33", e); end
    release_req();
    run_div(32'd7, 32'hFFFF_FFFE, 1'b1, e, b, o);
    checks++;
    if (quot !== 32'hFFFF_FFFD || rem !== 32'h1) begin
      failures++; $display("FAIL sdiv_neg_divisor quot=%h rem=%h expected fffffffd/00000001", quot, rem);
    end
    release_req();
    run_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, e, b, o);
    checks++;
    if (quot !== 32'h8000_0000 || rem !== 32'h0) begin
      failures++; $display("FAIL sdiv_overflow quot=%h rem=%h expected 80000000/00000000", quot, rem);
    end
    release_req();
  endtask

  task automatic test_div_zero();
    int e, b, o;
    run_div(32'h1234, 32'h0, 1'b0, e, b, o);
    checks++;
    if (e !== 1) begin failures++; $display("FAIL dz_latency got=%0d expected=1", e); end
    checks++;
    if (b !== 0) begin failures++; $display("FAIL dz_busy got=%0d expected=0", b); end
    checks++;
    if (quot !== 32'hFFFF_FFFF || rem !== 32'h1234) begin
      failures++; $display("FAIL dz_result quot=%h rem=%h expected ffffffff/00001234", quot, rem);
    end
    release_req();
  endtask

  task automatic test_annul();
    int e, b, o;
    int seen_ready;
    seen_ready = 0;
    @(negedge clk);
    opa = 32'd1000; opb = 32'd10; div_signed = 1'b0; div_req = 1'b1;
    repeat (10) begin
      @(posedge clk); #1;
      if (div_ready) seen_ready++;
    end
    @(negedge clk);
    annul = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (div_busy !== 1'b0 || div_ready !== 1'b0) begin
      failures++; $display("FAIL annul_idle busy=%b ready=%b expected 0/0", div_busy, div_ready);
    end
    @(negedge clk);
    annul = 1'b0; div_req = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (div_ready) seen_ready++;
    end
    checks++;
    if (seen_ready !== 0) begin failures++; $display("FAIL annul_no_ready got=%0d expected=0", seen_ready); end
    checks++;
    if (quot !== 32'hFFFF_FFFF || rem !== 32'h1234) begin
      failures++; $display("FAIL annul_no_write quot=%h rem=%h expected ffffffff/00001234", quot, rem);
    end
    run_div(32'd9, 32'd3, 1'b0, e, b, o);
    checks++;
    if (e !== 33 || quot !== 32'd3 || rem !== 32'd0) begin
      failures++; $display("FAIL annul_next_op edges=%0d quot=%0d rem=%0d expected 33/3/0", e, quot, rem);
    end
    release_req();
  endtask

  task automatic test_hold();
    int e, b, o;
    int bad;
    bad = 0;
    hold = 1'b1;
    run_div(32'd50, 32'd6, 1'b0, e, b, o);
    checks++;
    if (quot !== 32'd8 || rem !== 32'd2) begin
      failures++; $display("FAIL hold_result quot=%0d rem=%0d expected 8/2", quot, rem);
    end
    repeat (5) begin
      @(posedge clk); #1;
      if (div_ready !== 1'b1 || quot !== 32'd8 || rem !== 32'd2) bad++;
    end
    checks++;
    if (bad !== 0) begin failures++; $display("FAIL hold_stable bad_cycles=%0d expected=0", bad); end
    @(negedge clk);
    hold = 1'b0; div_req = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (div_ready !== 1'b0) begin failures++; $display("FAIL hold_release ready=%b expected=0", div_ready); end
    checks++;
    if (quot !== 32'd8 || rem !== 32'd2) begin
      failures++; $display("FAIL hold_retain quot=%0d rem=%0d expected 8/2", quot, rem);
    end
  endtask

  task automatic test_async_reset();
    int e, b, o;
    @(negedge clk);
    opa = 32'd100; opb = 32'd7; div_signed = 1'b0; div_req = 1'b1;
    repeat (5) @(posedge clk);
    #4;
    resetn = 1'b0;
    #1;
    checks++;
    if (div_busy !== 1'b0 || div_ready !== 1'b0 || quot !== 32'h0 || rem !== 32'h0) begin
      failures++;
      $display("FAIL async_reset busy=%b ready=%b quot=%h rem=%h expected all zero", div_busy, div_ready, quot, rem);
    end
    div_req = 1'b0;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (div_busy !== 1'b0 || div_ready !== 1'b0) begin
      failures++; $display("FAIL post_reset_idle busy=%b ready=%b expected 0/0", div_busy, div_ready);
    end
    run_div(32'd9, 32'd3, 1'b0, e, b, o);
    checks++;
    if (e !== 33 || quot !== 32'd3 || rem !== 32'd0) begin
      failures++; $display("FAIL post_reset_op edges=%0d quot=%0d rem=%0d expected 33/3/0", e, quot, rem);
    end
    release_req();
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_unsigned();
    test_signed();
    test_div_zero();
    test_annul();
    test_hold();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
